mem_share_shift_gen: RTL and testbench
======================================

// Module: mem_share_shift_gen
// PURPOSE
//  READ_COL_ADDR -> SHIFT_GEN -> ISSUE datapath of the memShare access-request scheduler.
//  - Accepts column addresses and adds the running delta FF, mod Z.
//  - Emits the resulting circular shift amount.
//  - Raises a one-cycle isGtr pulse on wrap-around; this pulse drives the delta reset generator.
//  - Consumes the generator's toggle-encoded reset to clear the delta FF synchronously.
// PARAMETERS
//  Z            96              lifting size; every shift is in [0, Z-1]
//  SHIFT_W      $clog2(Z)       width of shift_o and of the delta FF
//  ADDR_W       $clog2(Z)       width of col_addr_i
//  RST_POLARITY 1'b0            reset value of the delta reset generator output; must match the generator
// PORTS
//  sys_clk        in   1        clock
//  rstn           in   1        reset: synchronous, active-low
//  en_i           in   1        scheduler enable
//  col_addr_i     in   ADDR_W   column address read from the base-matrix ROM
//  col_valid_i    in   1        col_addr_i valid
//  col_ready_o    out  1        block ready to accept a column address
//  shift_o        out  SHIFT_W  generated shift amount
//  shift_valid_o  out  1        shift_o valid
//  shift_ready_i  in   1        downstream accepts shift_o
//  isGtr_o        out  1        wrap pulse, one cycle, to the delta reset generator
//  delta_rst_i    in   1        toggle-encoded delta reset from the delta reset generator
//  err_o          out  1        sticky: col_addr_i >= Z was accepted
// BEHAVIOUR
//  - Reset (rstn=0 at a clock edge):
//    - state=IDLE; col_ready_o, shift_valid_o, isGtr_o, err_o = 0; shift_o = 0.
//    - delta_q = 0; delta_rst_q = RST_POLARITY.
//    - Applies from any state, including mid-ISSUE; any pending shift is dropped.
//  - FSM states: IDLE, READ_COL_ADDR, SHIFT_GEN, ISSUE.
//  - IDLE -> READ_COL_ADDR when en_i=1.
//  - READ_COL_ADDR:
//    - col_ready_o=1 (registered from state).
//    - col_valid_i & col_ready_o: latch col_addr_q, go to SHIFT_GEN.
//    - en_i=0 with no handshake: go to IDLE.
//  - SHIFT_GEN (exactly 1 cycle):
//    - sum = col_addr_q + delta_q, computed at SHIFT_W+1 bits.
//    - gtr = (sum >= Z).
//    - shift_q = gtr ? sum-Z : sum.
//    - delta_q <= shift_q value (the same cycle's result).
//    - Go to ISSUE.
//  - ISSUE:
//    - shift_valid_o=1; shift_o=shift_q, held stable until shift_ready_i=1.
//    - isGtr_o=gtr only in the first ISSUE cycle, then 0 even under backpressure.
//    - On shift_ready_i: go to READ_COL_ADDR if en_i=1, else IDLE.
//  - Latency and throughput:
//    - Handshake accepted at edge T: shift_valid_o=1 from cycle T+2.
//    - Peak throughput: 1 shift per 3 cycles.
//  - Delta reset:
//    - delta_rst_q <= delta_rst_i every cycle.
//    - delta_rst_i != delta_rst_q: delta_q <= 0 at that edge.
//    - Clear has priority over the SHIFT_GEN capture.
//    - Generator turnaround: isGtr_o at cycle C; delta_rst_i toggles at C+1; delta_q=0 from C+2.
//      The next SHIFT_GEN is never earlier than C+2, so it always sees the cleared delta.
//  - Arithmetic: col_addr_q < Z and delta_q < Z guarantee sum < 2Z, so one conditional subtract suffices.
//  - Out-of-range address: col_addr_i >= Z accepted -> err_o=1 from the next cycle until rstn; shift_o is undefined.
//  - en_i deasserted mid-transaction: the transaction completes; the FSM then returns to IDLE.
// TESTING
//  - Reset: rstn=0 for 2 cycles then 1, en_i=1 -> cycle 1 after release: state=READ_COL_ADDR, col_ready_o=0; cycle 2: col_ready_o=1.
//  - No wrap: Z=96, delta_q=0, col=10 accepted at T -> shift_o=10, shift_valid_o=1 at T+2, isGtr_o=0, delta_q=10.
//  - Wrap plus reset round-trip: col=90 then col=20 -> shift 90, then shift 14 with one isGtr_o pulse; delta_rst_i toggles -> delta_q=0; col=5 -> shift_o=5.
//  - Boundary: delta_q=50, col=46 -> sum=96 -> shift_o=0, isGtr_o=1.
//  - Backpressure: shift_ready_i=0 for 5 ISSUE cycles -> shift_o and shift_valid_o stable, isGtr_o high 1 cycle only, col_ready_o=0.
//  - Error and mid-op reset: col=100 -> err_o=1 sticky; then rstn=0 during ISSUE -> all outputs 0 and delta_q=0 at the next edge.

Source files
------------

// File: rtl/mem_share_shift_gen.sv
// mem_share_shift_gen: READ_COL_ADDR -> SHIFT_GEN -> ISSUE datapath of the memShare scheduler
//
// Adds each accepted column address to a running delta, mod Z, and issues the
// result as a circular shift amount. A one-cycle isGtr_o pulse marks a wrap;
// the external delta reset generator answers with a toggle on delta_rst_i,
// which clears the delta register.
//
// Ports:
//   sys_clk        clock
//   rstn           synchronous active-low reset
//   en_i           scheduler enable
//   col_addr_i     column address from the base-matrix ROM
//   col_valid_i    col_addr_i valid
//   col_ready_o    ready to accept a column address
//   shift_o        generated shift amount
//   shift_valid_o  shift_o valid
//   shift_ready_i  downstream accepts shift_o
//   isGtr_o        one-cycle wrap pulse to the delta reset generator
//   delta_rst_i    toggle-encoded delta reset from the generator
//   err_o          sticky: an address >= Z was accepted
module mem_share_shift_gen #(
    parameter int   Z            = 96,
    parameter int   SHIFT_W      = $clog2(Z),
    parameter int   ADDR_W       = $clog2(Z),
    parameter logic RST_POLARITY = 1'b0
) (
    input  logic               sys_clk,
    input  logic               rstn,
    input  logic               en_i,
    input  logic [ADDR_W-1:0]  col_addr_i,
    input  logic               col_valid_i,
    output logic               col_ready_o,
    output logic [SHIFT_W-1:0] shift_o,
    output logic               shift_valid_o,
    input  logic               shift_ready_i,
    output logic               isGtr_o,
    input  logic               delta_rst_i,
    output logic               err_o
);
    typedef enum logic [1:0] {IDLE, READ_COL_ADDR, SHIFT_GEN, ISSUE} state_t;

    localparam logic [SHIFT_W:0] Z_S = (SHIFT_W+1)'(Z);
    localparam logic [ADDR_W:0]  Z_A = (ADDR_W+1)'(Z);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  col_addr_q;
    logic [SHIFT_W-1:0] delta_q, shift_q, shift_d;
    logic [SHIFT_W:0]   sum;
    logic               hs, gtr, delta_clr, delta_rst_q, err_q;
    logic               col_ready_q, col_ready_d;
    logic               shift_valid_q, shift_valid_d;
    logic               is_gtr_q, is_gtr_d;

    assign hs        = state_q == READ_COL_ADDR && col_valid_i && col_ready_q;
    // Both operands are < Z, so the sum is < 2Z and one conditional subtract wraps it.
    assign sum       = (SHIFT_W+1)'(col_addr_q) + (SHIFT_W+1)'(delta_q);
    assign gtr       = sum >= Z_S;
    assign shift_d   = SHIFT_W'(gtr ? sum - Z_S : sum);
    // Any level change on the generator output is a clear request.
    assign delta_clr = delta_rst_i != delta_rst_q;

    always_ff @(posedge sys_clk) begin
        if (!rstn)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:          state_d = en_i ? READ_COL_ADDR : IDLE;
            READ_COL_ADDR: state_d = hs ? SHIFT_GEN : (en_i ? READ_COL_ADDR : IDLE);
            SHIFT_GEN:     state_d = ISSUE;
            ISSUE:         state_d = shift_ready_i ? (en_i ? READ_COL_ADDR : IDLE) : ISSUE;
            default:       state_d = IDLE;
        endcase
    end

    // Registered outputs: ready lags one cycle when leaving IDLE but is
    // immediate on the ISSUE -> READ_COL_ADDR return, giving 3-cycle throughput.
    always_comb begin
        col_ready_d   = state_d == READ_COL_ADDR && state_q != IDLE;
        shift_valid_d = state_d == ISSUE;
        is_gtr_d      = state_q == SHIFT_GEN && gtr;
    end

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            col_ready_q   <= 1'b0;
            shift_valid_q <= 1'b0;
            is_gtr_q      <= 1'b0;
            err_q         <= 1'b0;
            col_addr_q    <= '0;
            shift_q       <= '0;
            delta_q       <= '0;
            delta_rst_q   <= RST_POLARITY;
        end else begin
            col_ready_q   <= col_ready_d;
            shift_valid_q <= shift_valid_d;
            is_gtr_q      <= is_gtr_d;
            delta_rst_q   <= delta_rst_i;
            if (hs)
                col_addr_q <= col_addr_i;
            if (hs && {1'b0, col_addr_i} >= Z_A)
                err_q <= 1'b1;
            if (state_q == SHIFT_GEN)
                shift_q <= shift_d;
            // Clear wins over the SHIFT_GEN capture.
            if (delta_clr)
                delta_q <= '0;
            else if (state_q == SHIFT_GEN)
                delta_q <= shift_d;
        end
    end

    assign col_ready_o   = col_ready_q;
    assign shift_valid_o = shift_valid_q;
    assign shift_o       = shift_q;
    assign isGtr_o       = is_gtr_q;
    assign err_o         = err_q;
endmodule

// File: tb/tb_mem_share_shift_gen.sv
// tb_mem_share_shift_gen: randomized self-checking bench for mem_share_shift_gen
module tb_mem_share_shift_gen;
    localparam int Z = 96;
    localparam int W = $clog2(Z);

    logic         sys_clk = 1'b0, rstn = 1'b0, en_i = 1'b0;
    logic         col_valid_i = 1'b0, shift_ready_i = 1'b0, delta_rst_i = 1'b0;
    logic [W-1:0] col_addr_i = '0;
    logic         col_ready_o, shift_valid_o, isGtr_o, err_o;
    logic [W-1:0] shift_o;

    int checks = 0, failures = 0;

    // Transaction-level reference: each accepted column gives (col + delta) mod Z;
    // delta becomes that result and any clear request zeroes it afterwards.
    int delta, exp_shift, pend_col, col_prev, n_shifts;
    bit exp_gtr, exp_valid, first, pend, exp_err, unk;
    bit hs_prev, clr_prev, cons_prev, gen_pend;
    bit hold_ready, rand_tog, rand_en, refill;
    int q[$];

    always #5 sys_clk = ~sys_clk;

    mem_share_shift_gen dut (
        .sys_clk(sys_clk), .rstn(rstn), .en_i(en_i),
        .col_addr_i(col_addr_i), .col_valid_i(col_valid_i), .col_ready_o(col_ready_o),
        .shift_o(shift_o), .shift_valid_o(shift_valid_o), .shift_ready_i(shift_ready_i),
        .isGtr_o(isGtr_o), .delta_rst_i(delta_rst_i), .err_o(err_o)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
        end
    endtask

    task automatic model_clear();
        delta = 0; exp_valid = 0; pend = 0; first = 0; exp_err = 0; unk = 0;
        hs_prev = 0; clr_prev = 0; cons_prev = 0; gen_pend = 0;
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        rstn = 1'b0; en_i = 1'b0; col_valid_i = 1'b0; shift_ready_i = 1'b0; delta_rst_i = 1'b0;
        @(negedge sys_clk);
        check("rst_ready", 32'(col_ready_o), 0);
        check("rst_valid", 32'(shift_valid_o), 0);
        check("rst_isgtr", 32'(isGtr_o), 0);
        check("rst_err", 32'(err_o), 0);
        check("rst_shift", 32'(shift_o), 0);
        @(negedge sys_clk);
        rstn = 1'b1; en_i = 1'b1;
        model_clear();
        @(negedge sys_clk);
        check("rel_ready_c1", 32'(col_ready_o), 0);
        @(negedge sys_clk);
        check("rel_ready_c2", 32'(col_ready_o), 1);
    endtask

    task automatic run(input int n);
        int s;
        for (int i = 0; i < n; i++) begin
            @(negedge sys_clk);
            // effects of the edge that just passed
            if (cons_prev) exp_valid = 0;
            first = 0;
            if (pend) begin
                s = pend_col + delta;
                exp_gtr = s >= Z;
                exp_shift = exp_gtr ? s - Z : s;
                delta = exp_shift;
                exp_valid = 1; first = 1; pend = 0;
                n_shifts++;
            end
            if (clr_prev) delta = 0;
            if (hs_prev) begin
                pend = 1; pend_col = col_prev;
                if (col_prev >= Z) begin exp_err = 1; unk = 1; end
            end
            check("valid", 32'(shift_valid_o), 32'(exp_valid));
            check("err", 32'(err_o), 32'(exp_err));
            if (exp_valid) check("ready_in_issue", 32'(col_ready_o), 0);
            if (exp_valid && !unk) begin
                check("shift", 32'(shift_o), 32'(exp_shift));
                check("isgtr", 32'(isGtr_o), 32'(first && exp_gtr));
            end
            // generator response and optional spurious clears
            clr_prev = 0;
            if (gen_pend) begin
                delta_rst_i = ~delta_rst_i; clr_prev = 1; gen_pend = 0;
            end else if (rand_tog && $urandom_range(19) == 0) begin
                delta_rst_i = ~delta_rst_i; clr_prev = 1;
            end
            if (isGtr_o) gen_pend = 1;
            // next-cycle stimulus
            en_i = rand_en ? ($urandom_range(9) != 0) : 1'b1;
            if (refill && q.size() == 0) q.push_back($urandom_range(Z - 1));
            col_valid_i = q.size() > 0 && $urandom_range(4) != 0;
            col_addr_i = q.size() > 0 ? W'(q[0]) : '0;
            hs_prev = col_valid_i && col_ready_o;
            if (hs_prev) col_prev = q.pop_front();
            shift_ready_i = hold_ready ? 1'b0 : ($urandom_range(2) != 0);
            cons_prev = shift_ready_i && shift_valid_o;
        end
    endtask

    initial begin
        n_shifts = 0;
        hold_ready = 0; rand_tog = 0; rand_en = 0; refill = 0;
        model_clear();
        do_reset();
        // no wrap, wrap plus generator round-trip, exact-Z boundary
        q = '{10, 80, 20, 5, 45, 46, 60};
        run(80);
        // backpressure on a wrapping shift (60 + 50 = 110)
        q.push_back(50);
        for (int k = 0; k < 30 && !pend; k++) run(1);
        hold_ready = 1;
        run(10);
        hold_ready = 0;
        run(10);
        // randomized traffic with enable drops and spurious clears
        rand_en = 1; rand_tog = 1; refill = 1;
        run(3000);
        rand_en = 0; rand_tog = 0; refill = 0;
        run(40);
        // out-of-range address, then reset while in ISSUE
        q.push_back(100);
        for (int k = 0; k < 40 && !unk; k++) run(1);
        hold_ready = 1;
        for (int k = 0; k < 10 && !exp_valid; k++) run(1);
        check("err_reach_issue", 32'(exp_valid && unk), 1);
        do_reset();
        hold_ready = 0;
        q.push_back(5);
        run(20);
        check("progress", 32'(n_shifts > 200), 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
